// File: rtl/ctrl_pipe_unit.sv
// RV32I/M control decoder feeding registered EX/MEM/WB control stages.
// Handles load-use interlock, downstream freeze, branch flush and counts illegal instructions.
module ctrl_pipe_unit #(
  parameter int STAGES = 3,
  parameter bit EN_M   = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic [6:0]       funct7_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  input  logic             pipe_stall_i,
  input  logic             flush_i,
  output logic             id_stall_o,
  output logic             ex_valid_o,
  output logic             mem_valid_o,
  output logic             wb_valid_o,
  output logic [7:0]       ex_ctrl_o,
  output logic [7:0]       mem_ctrl_o,
  output logic [7:0]       wb_ctrl_o,
  output logic [4:0]       ex_rd_o,
  output logic [4:0]       mem_rd_o,
  output logic [4:0]       wb_rd_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam int B_RDWE    = 0;
  localparam int B_MEMRE   = 1;
  localparam int B_MEMWE   = 2;
  localparam int B_BRANCH  = 3;
  localparam int B_JUMP    = 4;
  localparam int B_ALUIMM  = 5;
  localparam int B_PCSRC   = 6;
  localparam int B_ILLEGAL = 7;

  localparam logic [7:0]       ILLEGAL_BUNDLE = 8'h80;
  localparam logic [CNT_W-1:0] CNT_MAX        = {CNT_W{1'b1}};

  logic       w_legal;
  logic [7:0] w_rawCtrl;
  logic [7:0] w_decCtrl;
  logic       w_useRs1;
  logic       w_useRs2;
  logic       w_rs1Hit;
  logic       w_rs2Hit;
  logic       w_loadUse;
  logic       w_exLoadNew;
  logic       w_countIllegal;

  logic             r_exValid;
  logic [7:0]       r_exCtrl;
  logic [4:0]       r_exRd;
  logic [CNT_W-1:0] r_illegalCnt;

  // Opcode decode: control bits and register usage are set per opcode, legality per funct fields.
  always_comb begin
    w_legal   = 1'b0;
    w_rawCtrl = 8'h00;
    w_useRs1  = 1'b0;
    w_useRs2  = 1'b0;
    case (opcode_i)
      OPC_OP_IMM: begin
        w_rawCtrl[B_RDWE]   = 1'b1;
        w_rawCtrl[B_ALUIMM] = 1'b1;
        w_useRs1            = 1'b1;
        case (funct3_i)
          3'b001:  w_legal = (funct7_i == F7_BASE);
          3'b101:  w_legal = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
          default: w_legal = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_rawCtrl[B_RDWE] = 1'b1;
        w_useRs1          = 1'b1;
        w_useRs2          = 1'b1;
        w_legal = (funct7_i == F7_BASE)
               || ((funct7_i == F7_ALT) && ((funct3_i == 3'b000) || (funct3_i == 3'b101)))
               || ((funct7_i == F7_MUL) && EN_M);
      end
      OPC_LOAD: begin
        w_rawCtrl[B_RDWE]   = 1'b1;
        w_rawCtrl[B_MEMRE]  = 1'b1;
        w_rawCtrl[B_ALUIMM] = 1'b1;
        w_useRs1            = 1'b1;
        w_legal = (funct3_i != 3'b011) && (funct3_i != 3'b110) && (funct3_i != 3'b111);
      end
      OPC_STORE: begin
        w_rawCtrl[B_MEMWE]  = 1'b1;
        w_rawCtrl[B_ALUIMM] = 1'b1;
        w_useRs1            = 1'b1;
        w_useRs2            = 1'b1;
        w_legal = (funct3_i <= 3'b010);
      end
      OPC_BRANCH: begin
        w_rawCtrl[B_BRANCH] = 1'b1;
        w_useRs1            = 1'b1;
        w_useRs2            = 1'b1;
        w_legal = (funct3_i != 3'b010) && (funct3_i != 3'b011);
      end
      OPC_JAL: begin
        w_rawCtrl[B_RDWE]  = 1'b1;
        w_rawCtrl[B_JUMP]  = 1'b1;
        w_rawCtrl[B_PCSRC] = 1'b1;
        w_legal            = 1'b1;
      end
      OPC_JALR: begin
        w_rawCtrl[B_RDWE]   = 1'b1;
        w_rawCtrl[B_JUMP]   = 1'b1;
        w_rawCtrl[B_ALUIMM] = 1'b1;
        w_rawCtrl[B_PCSRC]  = 1'b1;
        w_useRs1            = 1'b1;
        w_legal = (funct3_i == 3'b000);
      end
      OPC_LUI: begin
        w_rawCtrl[B_RDWE]   = 1'b1;
        w_rawCtrl[B_ALUIMM] = 1'b1;
        w_legal             = 1'b1;
      end
      OPC_AUIPC: begin
        w_rawCtrl[B_RDWE]   = 1'b1;
        w_rawCtrl[B_ALUIMM] = 1'b1;
        w_rawCtrl[B_PCSRC]  = 1'b1;
        w_legal             = 1'b1;
      end
      default: w_legal = 1'b0;
    endcase

    if (!w_legal) begin
      w_decCtrl = ILLEGAL_BUNDLE;
    end else begin
      w_decCtrl         = w_rawCtrl;
      w_decCtrl[B_RDWE] = w_rawCtrl[B_RDWE] && (rd_i != 5'd0);
    end
  end

  // A load in EX whose destination feeds this instruction cannot forward in time.
  assign w_rs1Hit  = w_useRs1 && (rs1_i == r_exRd);
  assign w_rs2Hit  = w_useRs2 && (rs2_i == r_exRd);
  assign w_loadUse = id_valid_i && r_exValid && r_exCtrl[B_MEMRE]
                  && (r_exRd != 5'd0) && (w_rs1Hit || w_rs2Hit);

  assign id_stall_o     = pipe_stall_i || w_loadUse;
  assign w_exLoadNew    = !flush_i && !pipe_stall_i && !w_loadUse;
  assign w_countIllegal = w_exLoadNew && id_valid_i && w_decCtrl[B_ILLEGAL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exValid <= 1'b0;
      r_exCtrl  <= 8'h00;
      r_exRd    <= 5'd0;
    end else if (flush_i || (!pipe_stall_i && w_loadUse)) begin
      r_exValid <= 1'b0;
      r_exCtrl  <= 8'h00;
      r_exRd    <= 5'd0;
    end else if (!pipe_stall_i) begin
      r_exValid <= id_valid_i;
      r_exCtrl  <= w_decCtrl;
      r_exRd    <= rd_i;
    end
  end

  assign ex_valid_o = r_exValid;
  assign ex_ctrl_o  = r_exCtrl;
  assign ex_rd_o    = r_exRd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegalCnt <= '0;
    end else if (w_countIllegal && (r_illegalCnt != CNT_MAX)) begin
      r_illegalCnt <= r_illegalCnt + CNT_W'(1);
    end
  end

  assign illegal_cnt_o = r_illegalCnt;

  // MEM and WB advance on every unfrozen edge, including flush cycles.
  if (STAGES >= 2) begin : g_mem
    logic       r_memValid;
    logic [7:0] r_memCtrl;
    logic [4:0] r_memRd;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_memValid <= 1'b0;
        r_memCtrl  <= 8'h00;
        r_memRd    <= 5'd0;
      end else if (!pipe_stall_i) begin
        r_memValid <= r_exValid;
        r_memCtrl  <= r_exCtrl;
        r_memRd    <= r_exRd;
      end
    end

    assign mem_valid_o = r_memValid;
    assign mem_ctrl_o  = r_memCtrl;
    assign mem_rd_o    = r_memRd;
  end else begin : g_noMem
    assign mem_valid_o = 1'b0;
    assign mem_ctrl_o  = 8'h00;
    assign mem_rd_o    = 5'd0;
  end

  if (STAGES >= 3) begin : g_wb
    logic       r_wbValid;
    logic [7:0] r_wbCtrl;
    logic [4:0] r_wbRd;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wbValid <= 1'b0;
        r_wbCtrl  <= 8'h00;
        r_wbRd    <= 5'd0;
      end else if (!pipe_stall_i) begin
        r_wbValid <= mem_valid_o;
        r_wbCtrl  <= mem_ctrl_o;
        r_wbRd    <= mem_rd_o;
      end
    end

    assign wb_valid_o = r_wbValid;
    assign wb_ctrl_o  = r_wbCtrl;
    assign wb_rd_o    = r_wbRd;
  end else begin : g_noWb
    assign wb_valid_o = 1'b0;
    assign wb_ctrl_o  = 8'h00;
    assign wb_rd_o    = 5'd0;
  end

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: two instances (full default and STAGES=1/EN_M=1/CNT_W=2)
// share stimulus and are compared each cycle against a table-driven pipeline model.
module tb_ctrl_pipe_unit;

  logic       clk;
  logic       rstN;
  logic       idValid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;
  logic       pipeStall;
  logic       flush;

  logic [1:0]      idStall;
  logic [1:0]      exValid;
  logic [1:0]      memValid;
  logic [1:0]      wbValid;
  logic [1:0][7:0] exCtrl;
  logic [1:0][7:0] memCtrl;
  logic [1:0][7:0] wbCtrl;
  logic [1:0][4:0] exRd;
  logic [1:0][4:0] memRd;
  logic [1:0][4:0] wbRd;
  logic [15:0]     cnt0;
  logic [1:0]      cnt1;

  int checks = 0;
  int errors = 0;

  bit          mValid [2][3];
  logic [7:0]  mCtrl  [2][3];
  logic [4:0]  mRd    [2][3];
  int unsigned mCnt   [2];
  int          mStages [2] = '{3, 1};
  bit          mEnM    [2] = '{1'b0, 1'b1};
  int unsigned mCntMax [2] = '{65535, 3};

  ctrl_pipe_unit dut0 (
    .clk(clk), .rst_n(rstN), .id_valid_i(idValid),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .pipe_stall_i(pipeStall), .flush_i(flush),
    .id_stall_o(idStall[0]),
    .ex_valid_o(exValid[0]), .mem_valid_o(memValid[0]), .wb_valid_o(wbValid[0]),
    .ex_ctrl_o(exCtrl[0]), .mem_ctrl_o(memCtrl[0]), .wb_ctrl_o(wbCtrl[0]),
    .ex_rd_o(exRd[0]), .mem_rd_o(memRd[0]), .wb_rd_o(wbRd[0]),
    .illegal_cnt_o(cnt0)
  );

  ctrl_pipe_unit #(.STAGES(1), .EN_M(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rstN), .id_valid_i(idValid),
    .opcode_i(opcode), .funct3_i(funct3), .funct7_i(funct7),
    .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
    .pipe_stall_i(pipeStall), .flush_i(flush),
    .id_stall_o(idStall[1]),
    .ex_valid_o(exValid[1]), .mem_valid_o(memValid[1]), .wb_valid_o(wbValid[1]),
    .ex_ctrl_o(exCtrl[1]), .mem_ctrl_o(memCtrl[1]), .wb_ctrl_o(wbCtrl[1]),
    .ex_rd_o(exRd[1]), .mem_rd_o(memRd[1]), .wb_rd_o(wbRd[1]),
    .illegal_cnt_o(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bundle comes from a lookup of the opcode's fixed control set, then legality and rd=x0 masking.
  function automatic logic [7:0] decodeRef(input logic [6:0] op, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [4:0] rdIdx,
                                           input bit enM);
    bit         legal;
    logic [7:0] b;
    legal = 1'b1;
    case (op)
      7'h13: begin b = 8'h21; if (f3 == 3'd1) legal = (f7 == 7'h00);
                              else if (f3 == 3'd5) legal = (f7 == 7'h00 || f7 == 7'h20); end
      7'h33: begin b = 8'h01; legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))
                                   || (f7 == 7'h01 && enM); end
      7'h03: begin b = 8'h23; legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5); end
      7'h23: begin b = 8'h24; legal = (f3 < 3'd3); end
      7'h63: begin b = 8'h08; legal = !(f3 == 3'd2 || f3 == 3'd3); end
      7'h6f: b = 8'h51;
      7'h67: begin b = 8'h71; legal = (f3 == 3'd0); end
      7'h37: b = 8'h21;
      7'h17: b = 8'h61;
      default: begin b = 8'h00; legal = 1'b0; end
    endcase
    if (!legal) return 8'h80;
    if (rdIdx == 5'd0) b[0] = 1'b0;
    return b;
  endfunction

  function automatic bit modelLoadUse(input int d);
    bit useRs1;
    bit useRs2;
    useRs1 = (opcode == 7'h13 || opcode == 7'h33 || opcode == 7'h03 ||
              opcode == 7'h23 || opcode == 7'h63 || opcode == 7'h67);
    useRs2 = (opcode == 7'h33 || opcode == 7'h23 || opcode == 7'h63);
    return idValid && mValid[d][0] && mCtrl[d][0][1] && (mRd[d][0] != 5'd0)
        && ((useRs1 && rs1 == mRd[d][0]) || (useRs2 && rs2 == mRd[d][0]));
  endfunction

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      mCnt[d] = 0;
      for (int s = 0; s < 3; s++) begin
        mValid[d][s] = 1'b0; mCtrl[d][s] = 8'h00; mRd[d][s] = 5'd0;
      end
    end
  endtask

  task automatic modelShift(input int d);
    for (int s = 2; s > 0; s--) begin
      mValid[d][s] = mValid[d][s-1]; mCtrl[d][s] = mCtrl[d][s-1]; mRd[d][s] = mRd[d][s-1];
    end
  endtask

  task automatic modelBubble(input int d);
    mValid[d][0] = 1'b0; mCtrl[d][0] = 8'h00; mRd[d][0] = 5'd0;
  endtask

  task automatic modelStep();
    for (int d = 0; d < 2; d++) begin
      bit lu;
      lu = modelLoadUse(d);
      if (flush) begin
        if (!pipeStall) modelShift(d);
        modelBubble(d);
      end else if (pipeStall) begin
      end else if (lu) begin
        modelShift(d);
        modelBubble(d);
      end else begin
        modelShift(d);
        mValid[d][0] = idValid;
        mCtrl[d][0]  = decodeRef(opcode, funct3, funct7, rd, mEnM[d]);
        mRd[d][0]    = rd;
        if (idValid && mCtrl[d][0][7] && mCnt[d] < mCntMax[d]) mCnt[d]++;
      end
      for (int s = mStages[d]; s < 3; s++) begin
        mValid[d][s] = 1'b0; mCtrl[d][s] = 8'h00; mRd[d][s] = 5'd0;
      end
    end
  endtask

  task automatic checkAll(input string phase);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s d%0d idStall", phase, d), idStall[d], pipeStall || modelLoadUse(d));
      checkOutput($sformatf("%s d%0d exValid", phase, d), exValid[d], mValid[d][0]);
      checkOutput($sformatf("%s d%0d exCtrl", phase, d), exCtrl[d], mCtrl[d][0]);
      checkOutput($sformatf("%s d%0d exRd", phase, d), exRd[d], mRd[d][0]);
      checkOutput($sformatf("%s d%0d memValid", phase, d), memValid[d], mValid[d][1]);
      checkOutput($sformatf("%s d%0d memCtrl", phase, d), memCtrl[d], mCtrl[d][1]);
      checkOutput($sformatf("%s d%0d memRd", phase, d), memRd[d], mRd[d][1]);
      checkOutput($sformatf("%s d%0d wbValid", phase, d), wbValid[d], mValid[d][2]);
      checkOutput($sformatf("%s d%0d wbCtrl", phase, d), wbCtrl[d], mCtrl[d][2]);
      checkOutput($sformatf("%s d%0d wbRd", phase, d), wbRd[d], mRd[d][2]);
    end
    checkOutput({phase, " d0 cnt"}, cnt0, mCnt[0]);
    checkOutput({phase, " d1 cnt"}, cnt1, mCnt[1]);
  endtask

  task automatic driveInputs(input logic v, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                             input logic [4:0] d, input logic st, input logic fl);
    idValid = v; opcode = op; funct3 = f3; funct7 = f7;
    rs1 = s1; rs2 = s2; rd = d; pipeStall = st; flush = fl;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic stepCycle(input string phase);
    #1;
    checkAll(phase);
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic v, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [4:0] d, input logic st, input logic fl, input string phase);
    driveInputs(v, op, f3, f7, s1, s2, d, st, fl);
    stepCycle(phase);
  endtask

  logic [6:0] opTable [9] = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

  initial begin
    rstN = 1'b0;
    driveInputs(0, 7'h13, 0, 0, 0, 0, 0, 0, 0);
    modelReset();
    repeat (2) begin
      @(negedge clk);
      #1;
      checkAll("reset");
    end
    rstN = 1'b1;

    $display("[TB] ADDI pipeline latency");
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd5, 0, 0, "addi");
    checkOutput("addi exCtrl", exCtrl[0], 8'h21);
    checkOutput("addi exRd", exRd[0], 5'd5);
    applyStimulus(0, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, "idle");
    applyStimulus(0, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, "idle");
    checkOutput("addi wbValid", wbValid[0], 1'b1);
    checkOutput("addi wbRd", wbRd[0], 5'd5);
    checkOutput("stages1 memValid", memValid[1], 1'b0);

    $display("[TB] load-use hazard");
    applyStimulus(1, 7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd7, 0, 0, "lw");
    driveInputs(1, 7'h33, 3'd0, 7'h00, 5'd7, 5'd1, 5'd8, 0, 0);
    #1;
    checkOutput("lu stall", idStall[0], 1'b1);
    stepCycle("lu");
    checkOutput("lu bubble", exValid[0], 1'b0);
    checkOutput("lu stall released", idStall[0], 1'b0);
    stepCycle("add");
    checkOutput("add exCtrl", exCtrl[0], 8'h01);
    checkOutput("add exRd", exRd[0], 5'd8);

    $display("[TB] no-hazard cases");
    applyStimulus(1, 7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd0, 0, 0, "lwx0");
    driveInputs(1, 7'h33, 3'd0, 7'h00, 5'd0, 5'd3, 5'd4, 0, 0);
    #1;
    checkOutput("x0 no stall", idStall[0], 1'b0);
    stepCycle("addx0");
    applyStimulus(1, 7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd7, 0, 0, "lw7");
    driveInputs(1, 7'h37, 3'd0, 7'h00, 5'd7, 5'd7, 5'd9, 0, 0);
    #1;
    checkOutput("lui no stall", idStall[0], 1'b0);
    stepCycle("lui");

    $display("[TB] RV32M and illegal shifts");
    applyStimulus(1, 7'h33, 3'd0, 7'h01, 5'd2, 5'd3, 5'd10, 0, 0, "mul");
    checkOutput("mul d0 exCtrl", exCtrl[0], 8'h80);
    checkOutput("mul d1 exCtrl", exCtrl[1], 8'h01);
    checkOutput("mul d0 cnt", cnt0, 16'd1);
    applyStimulus(1, 7'h13, 3'd1, 7'h20, 5'd2, 5'd0, 5'd11, 0, 0, "slli");
    checkOutput("slli exCtrl", exCtrl[0], 8'h80);

    $display("[TB] freeze and flush");
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 0, 0, "fill");
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd2, 0, 0, "fill");
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd3, 0, 0, "fill");
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd4, 1, 0, "freeze");
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd4, 1, 0, "freeze");
    checkOutput("freeze exRd", exRd[0], 5'd3);
    checkOutput("freeze memRd", memRd[0], 5'd2);
    checkOutput("freeze wbRd", wbRd[0], 5'd1);
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd4, 1, 1, "flushfreeze");
    checkOutput("flush exValid", exValid[0], 1'b0);
    checkOutput("flush memRd", memRd[0], 5'd2);
    checkOutput("flush wbRd", wbRd[0], 5'd1);
    checkOutput("flush wbValid", wbValid[0], 1'b1);

    $display("[TB] counter saturation");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, 7'h7f, 3'd0, 7'h00, 5'd0, 5'd0, 5'd1, 0, 0, "illegal");
    checkOutput("cnt saturate", cnt1, 2'd3);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [6:0] op;
      logic [6:0] f7;
      int sel;
      sel = $urandom_range(0, 9);
      op  = (sel == 9) ? 7'($urandom) : opTable[sel];
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      applyStimulus(($urandom_range(0, 9) < 8), op, 3'($urandom), f7,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), "random");
    end

    $display("[TB] asynchronous reset mid-stream");
    applyStimulus(1, 7'h03, 3'd2, 7'h00, 5'd1, 5'd0, 5'd6, 0, 0, "prereset");
    driveInputs(0, 7'h13, 0, 0, 0, 0, 0, 0, 0);
    #2;
    rstN = 1'b0;
    #1;
    modelReset();
    checkAll("asyncreset");
    @(negedge clk);
    rstN = 1'b1;
    applyStimulus(1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd5, 0, 0, "postreset");
    applyStimulus(0, 7'h13, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 0, 0, "postreset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
